// File: rtl/cpu_int_ack_ctrl.sv
// Interrupt latch/acknowledge controller for a Z80-class CPU core.
// Channel 0 is the NMI source. Channels 1..NCH-1 are merged onto IRQo, and the
// lowest-numbered pending channel has the highest priority. A pending request is
// cleared by a vector fetch (M1 with a matching address), by a disable, or by a
// clear strobe. Each channel is either edge-latched or level-following. Sticky
// overrun flags record edges that arrive while the channel is already pending.
//
// Ports:
//   CLK    system clock, rising edge
//   RST    asynchronous reset, active-high
//   CEN    clock enable; all state holds while low
//   AD     CPU address bus
//   M1     opcode/vector fetch strobe
//   REQ    raw interrupt request lines
//   EN     per-channel enable
//   CLR    per-channel clear strobe (pending + overrun)
//   NMIo   pending state of channel 0
//   IRQo   OR of pending channels 1..NCH-1
//   IRQ_ID index of lowest pending IRQ channel, 0 if none
//   PEND   per-channel pending flags
//   OVR    per-channel sticky overrun flags
module cpu_int_ack_ctrl #(
    parameter int unsigned     NCH     = 4,
    parameter int unsigned     AW      = 16,
    parameter logic [AW-1:0]   NMI_VEC = 16'h0066,
    parameter logic [AW-1:0]   IRQ_VEC = 16'h0038,
    parameter logic [NCH-1:0]  EDGE    = {NCH{1'b1}},
    parameter int unsigned     IDW     = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CEN,
    input  logic [AW-1:0]  AD,
    input  logic           M1,
    input  logic [NCH-1:0] REQ,
    input  logic [NCH-1:0] EN,
    input  logic [NCH-1:0] CLR,
    output logic           NMIo,
    output logic           IRQo,
    output logic [IDW-1:0] IRQ_ID,
    output logic [NCH-1:0] PEND,
    output logic [NCH-1:0] OVR
);

    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] ovr_q, ovr_d;
    logic [NCH-1:0] req_prev_q;
    logic           nmi_match_q, irq_match_q;
    logic [IDW-1:0] irq_id_q, irq_id_d;

    logic           nmi_match, irq_match;
    logic           ack_nmi, ack_irq;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] irq_tgt;
    logic           irq_found;
    logic [NCH-1:0] ack_hit;

    assign nmi_match = M1 && (AD == NMI_VEC);
    assign irq_match = M1 && (AD == IRQ_VEC);
    // A held fetch acknowledges only on its first matching cycle.
    assign ack_nmi   = nmi_match && !nmi_match_q;
    assign ack_irq   = irq_match && !irq_match_q;
    assign rise      = REQ & ~req_prev_q;

    // IRQ ack target is chosen from the pending state before this cycle's update.
    always_comb begin
        irq_tgt   = '0;
        irq_found = 1'b0;
        for (int i = 1; i < int'(NCH); i++) begin
            if (pend_q[i] && !irq_found) begin
                irq_tgt[i] = 1'b1;
                irq_found  = 1'b1;
            end
        end
    end

    assign ack_hit = (irq_tgt & {NCH{ack_irq}}) | {{(NCH-1){1'b0}}, ack_nmi};

    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        for (int i = 0; i < int'(NCH); i++) begin
            if (EDGE[i]) begin
                if (!EN[i] || CLR[i]) begin
                    pend_d[i] = 1'b0;
                    if (CLR[i]) begin
                        ovr_d[i] = 1'b0;
                    end
                end else if (ack_hit[i]) begin
                    // An edge coinciding with the ack is swallowed without overrun.
                    pend_d[i] = 1'b0;
                end else if (rise[i]) begin
                    if (pend_q[i]) begin
                        ovr_d[i] = 1'b1;
                    end
                    pend_d[i] = 1'b1;
                end
            end else begin
                pend_d[i] = REQ[i] && EN[i] && !CLR[i];
                ovr_d[i]  = 1'b0;
            end
        end
    end

    always_comb begin
        irq_id_d = '0;
        for (int i = int'(NCH) - 1; i >= 1; i--) begin
            if (pend_d[i]) begin
                irq_id_d = IDW'(i);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q      <= '0;
            ovr_q       <= '0;
            req_prev_q  <= '0;
            nmi_match_q <= 1'b0;
            irq_match_q <= 1'b0;
            irq_id_q    <= '0;
        end else if (CEN) begin
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            req_prev_q  <= REQ;
            nmi_match_q <= nmi_match;
            irq_match_q <= irq_match;
            irq_id_q    <= irq_id_d;
        end
    end

    assign PEND   = pend_q;
    assign OVR    = ovr_q;
    assign NMIo   = pend_q[0];
    assign IRQo   = |pend_q[NCH-1:1];
    assign IRQ_ID = irq_id_q;

endmodule

// File: tb/tb_cpu_int_ack_ctrl.sv
// Bench for cpu_int_ack_ctrl: one all-edge instance and one with channel 1 in
// level mode, driven from shared inputs and compared against a reference model.
module tb_cpu_int_ack_ctrl;

    localparam logic [15:0] NMI_A = 16'h0066;
    localparam logic [15:0] IRQ_A = 16'h0038;

    logic        CLK = 1'b0;
    logic        RST, CEN, M1;
    logic [15:0] AD;
    logic [3:0]  REQ, EN, CLR;

    logic       nmi0, irq0, nmi1, irq1;
    logic [2:0] id0, id1;
    logic [3:0] pend0, ovr0, pend1, ovr1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, index 0 = all-edge instance, 1 = ch1 level instance.
    bit [3:0] m_pend [2];
    bit [3:0] m_ovr  [2];
    bit [3:0] m_prev [2];
    bit       m_nm   [2];
    bit       m_im   [2];

    always #5 CLK = ~CLK;

    cpu_int_ack_ctrl #(.NCH(4), .AW(16), .NMI_VEC(16'h0066), .IRQ_VEC(16'h0038),
                       .EDGE(4'b1111), .IDW(3)) dut (
        .CLK(CLK), .RST(RST), .CEN(CEN), .AD(AD), .M1(M1), .REQ(REQ), .EN(EN),
        .CLR(CLR), .NMIo(nmi0), .IRQo(irq0), .IRQ_ID(id0), .PEND(pend0), .OVR(ovr0)
    );

    cpu_int_ack_ctrl #(.NCH(4), .AW(16), .NMI_VEC(16'h0066), .IRQ_VEC(16'h0038),
                       .EDGE(4'b1101), .IDW(3)) dut_lvl (
        .CLK(CLK), .RST(RST), .CEN(CEN), .AD(AD), .M1(M1), .REQ(REQ), .EN(EN),
        .CLR(CLR), .NMIo(nmi1), .IRQo(irq1), .IRQ_ID(id1), .PEND(pend1), .OVR(ovr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0;
            m_ovr[k]  = '0;
            m_prev[k] = '0;
            m_nm[k]   = 1'b0;
            m_im[k]   = 1'b0;
        end
    endtask

    // One CEN-qualified clock edge of the reference behaviour.
    task automatic model_clk();
        for (int k = 0; k < 2; k++) begin
            bit [3:0] is_edge;
            bit       nmatch, imatch, take_n, take_i;
            int       tgt;
            bit [3:0] np, no;
            if (!CEN) continue;
            is_edge = (k == 0) ? 4'b1111 : 4'b1101;
            nmatch  = M1 && (AD == NMI_A);
            imatch  = M1 && (AD == IRQ_A);
            take_n  = nmatch && !m_nm[k];
            take_i  = imatch && !m_im[k];
            tgt     = -1;
            for (int c = 1; c < 4; c++) if (tgt < 0 && m_pend[k][c]) tgt = c;
            np = m_pend[k];
            no = m_ovr[k];
            for (int c = 0; c < 4; c++) begin
                bit acked;
                acked = (c == 0) ? take_n : (take_i && tgt == c);
                if (!is_edge[c]) begin
                    np[c] = REQ[c] & EN[c] & ~CLR[c];
                    no[c] = 1'b0;
                end else if (!EN[c] || CLR[c]) begin
                    np[c] = 1'b0;
                    if (CLR[c]) no[c] = 1'b0;
                end else if (acked) begin
                    np[c] = 1'b0;
                end else if (REQ[c] && !m_prev[k][c]) begin
                    if (m_pend[k][c]) no[c] = 1'b1;
                    np[c] = 1'b1;
                end
            end
            m_pend[k] = np;
            m_ovr[k]  = no;
            m_prev[k] = REQ;
            m_nm[k]   = nmatch;
            m_im[k]   = imatch;
        end
    endtask

    function automatic logic [2:0] exp_id(input bit [3:0] p);
        for (int c = 1; c < 4; c++) if (p[c]) return 3'(c);
        return 3'd0;
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic [3:0] p, o;
            logic       n, q;
            logic [2:0] d;
            p = (k == 0) ? pend0 : pend1;
            o = (k == 0) ? ovr0  : ovr1;
            n = (k == 0) ? nmi0  : nmi1;
            q = (k == 0) ? irq0  : irq1;
            d = (k == 0) ? id0   : id1;
            chk($sformatf("%s_pend%0d", tag, k), p, m_pend[k]);
            chk($sformatf("%s_ovr%0d", tag, k), o, m_ovr[k]);
            chk($sformatf("%s_nmi%0d", tag, k), n, m_pend[k][0]);
            chk($sformatf("%s_irq%0d", tag, k), q, |m_pend[k][3:1]);
            chk($sformatf("%s_id%0d", tag, k), d, exp_id(m_pend[k]));
        end
    endtask

    task automatic step(input string tag);
        model_clk();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        RST = 1'b1; CEN = 1'b1; M1 = 1'b0; AD = 16'h0000;
        REQ = 4'h0; EN = 4'hF; CLR = 4'h0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        RST = 1'b0;

        // T1: NMI latch, single ack on a held fetch, no re-assert while held high.
        REQ = 4'b0001;
        step("t1_req");
        chk("t1_nmi_set", nmi0, 1'b1);
        M1 = 1'b1; AD = NMI_A;
        step("t1_ack");
        chk("t1_nmi_ack", nmi0, 1'b0);
        step("t1_hold1");
        step("t1_hold2");
        chk("t1_nmi_held", nmi0, 1'b0);
        M1 = 1'b0; REQ = 4'b0000;
        step("t1_end");

        // T2: priority merge and successive IRQ acks.
        REQ = 4'b1000;
        step("t2_r3");
        REQ = 4'b1010;
        step("t2_r1");
        chk("t2_id1", id0, 3'd1);
        chk("t2_irq", irq0, 1'b1);
        M1 = 1'b1; AD = IRQ_A;
        step("t2_ack1");
        chk("t2_pend_after1", pend0, 4'b1000);
        chk("t2_id3", id0, 3'd3);
        M1 = 1'b0;
        step("t2_gap");
        M1 = 1'b1;
        step("t2_ack2");
        chk("t2_irq_clr", irq0, 1'b0);
        chk("t2_id0", id0, 3'd0);
        M1 = 1'b0; REQ = 4'b0000;
        step("t2_end");

        // T3: overrun on a second edge, cleared by CLR.
        REQ = 4'b0100; step("t3_p1");
        REQ = 4'b0000; step("t3_lo");
        REQ = 4'b0100; step("t3_p2");
        chk("t3_pend2", pend0[2], 1'b1);
        chk("t3_ovr2", ovr0[2], 1'b1);
        REQ = 4'b0000; CLR = 4'b0100;
        step("t3_clr");
        chk("t3_pend2_clr", pend0[2], 1'b0);
        chk("t3_ovr2_clr", ovr0[2], 1'b0);
        CLR = 4'b0000;

        // T4: edge coinciding with the first NMI ack cycle is consumed.
        M1 = 1'b1; AD = NMI_A; REQ = 4'b0001;
        step("t4_coll");
        chk("t4_nmi", nmi0, 1'b0);
        chk("t4_ovr0", ovr0[0], 1'b0);
        M1 = 1'b0; REQ = 4'b0000;
        step("t4_end");

        // T5: level channel ignores acks, follows EN; CEN low freezes everything.
        REQ = 4'b0010;
        step("t5_lvl");
        chk("t5_lvl_set", pend1[1], 1'b1);
        M1 = 1'b1; AD = IRQ_A;
        step("t5_ack");
        chk("t5_lvl_ack", pend1[1], 1'b1);
        M1 = 1'b0; EN = 4'b1101;
        step("t5_mask");
        chk("t5_lvl_mask", pend1[1], 1'b0);
        EN = 4'hF; REQ = 4'b1001;
        step("t5_pre");
        CEN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            REQ = 4'(i * 3 + 6); CLR = 4'hF; M1 = 1'b1; AD = NMI_A;
            step("t5_frozen");
        end
        CEN = 1'b1; CLR = 4'h0; M1 = 1'b0; REQ = 4'b0000;
        step("t5_end");

        // T6: asynchronous reset mid-pending, then an already-high REQ counts as an edge.
        REQ = 4'b0100;
        step("t6_pend");
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_all("t6_async");
        chk("t6_pend_zero", pend0, 4'b0000);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step("t6_release");
        chk("t6_pend2", pend0[2], 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int unsigned a;
            REQ = 4'($urandom);
            EN  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            CLR = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            CEN = ($urandom_range(0, 5) != 0);
            M1  = ($urandom_range(0, 2) == 0);
            a   = $urandom_range(0, 3);
            AD  = (a == 0) ? NMI_A : (a == 1) ? IRQ_A : 16'($urandom);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
